// File: rtl/bcd_disp_pkg.sv
// Shared glyph constants for the multiplexed BCD display scanner.
// All glyphs are active-high {g,f,e,d,c,b,a}.
package bcd_disp_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;

    localparam logic [6:0] SEG_0    = 7'b0111111;
    localparam logic [6:0] SEG_1    = 7'b0000110;
    localparam logic [6:0] SEG_2    = 7'b1011011;
    localparam logic [6:0] SEG_3    = 7'b1001111;
    localparam logic [6:0] SEG_4    = 7'b1100110;
    localparam logic [6:0] SEG_5    = 7'b1101101;
    localparam logic [6:0] SEG_6    = 7'b1111101;
    localparam logic [6:0] SEG_7    = 7'b0000111;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1101111;
    localparam logic [6:0] SEG_DASH = 7'b1000000;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder, active-high output.
// Non-BCD codes render as a dash so a corrupted counter digit is visible.
module bcd_to_seg7
    import bcd_disp_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        if (bcd_i <= BCD_MAX) begin
            case (bcd_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_OFF;
            endcase
        end
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Multiplexed 7-segment scanner: one shared segment bus, one-hot anodes,
// digits snapshotted once per frame so a counting source never tears.
module bcd_display_scanner
    import bcd_disp_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter bit ACTIVE_LOW  = 1'b1
)
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_tick
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]                presc_q, presc_d;
    logic [IW-1:0]                idx_q, idx_d;
    logic [NUM_DIGITS-1:0][3:0]   shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]        shadowDp_q, shadowDp_d;
    logic                         framePending_q, framePending_d;
    logic [6:0]                   segOn_q, segOn_d;
    logic                         dpOn_q, dpOn_d;
    logic [NUM_DIGITS-1:0]        anOn_q, anOn_d;
    logic                         frameTick_q, frameTick_d;

    logic       tick;
    logic       wrap;
    logic       blankDigit;
    logic [3:0] curDigit;
    logic [6:0] decoded;

    assign tick     = enable && (presc_q == PRESC_LAST);
    assign wrap     = tick && (idx_q == IDX_LAST);
    assign curDigit = shadow_q[idx_q];

    bcd_to_seg7 u_decoder (
        .bcd_i (curDigit),
        .seg_o (decoded)
    );

    // A digit is a leading zero when it and every more-significant digit is zero.
    always_comb begin
        blankDigit = blank_lz && (idx_q != '0);
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if ((j >= int'(idx_q)) && (shadow_q[j] != 4'd0)) begin
                blankDigit = 1'b0;
            end
        end
    end

    always_comb begin
        presc_d        = presc_q;
        idx_d          = idx_q;
        shadow_d       = shadow_q;
        shadowDp_d     = shadowDp_q;
        framePending_d = framePending_q;
        segOn_d        = SEG_OFF;
        dpOn_d         = 1'b0;
        anOn_d         = '0;
        frameTick_d    = 1'b0;

        if (enable) begin
            presc_d        = tick ? '0 : presc_q + 1'b1;
            framePending_d = wrap;
            anOn_d[idx_q]  = 1'b1;
            segOn_d        = blankDigit ? SEG_OFF : decoded;
            dpOn_d         = shadowDp_q[idx_q];
            frameTick_d    = framePending_q;
        end
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        if (wrap) begin
            shadow_d   = digits_in;
            shadowDp_d = dp_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q        <= '0;
            idx_q          <= '0;
            shadow_q       <= '0;
            shadowDp_q     <= '0;
            framePending_q <= 1'b0;
            segOn_q        <= SEG_OFF;
            dpOn_q         <= 1'b0;
            anOn_q         <= '0;
            frameTick_q    <= 1'b0;
        end else begin
            presc_q        <= presc_d;
            idx_q          <= idx_d;
            shadow_q       <= shadow_d;
            shadowDp_q     <= shadowDp_d;
            framePending_q <= framePending_d;
            segOn_q        <= segOn_d;
            dpOn_q         <= dpOn_d;
            anOn_q         <= anOn_d;
            frameTick_q    <= frameTick_d;
        end
    end

    assign seg_out    = ACTIVE_LOW ? ~segOn_q : segOn_q;
    assign dp_out     = ACTIVE_LOW ? ~dpOn_q  : dpOn_q;
    assign an_out     = ACTIVE_LOW ? ~anOn_q  : anOn_q;
    assign frame_tick = frameTick_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Scoreboard bench for bcd_display_scanner: a frame-level model predicts each
// cycle's pins from a count of enabled cycles; a monitor pops and compares.
module tb_bcd_display_scanner;

    localparam int N   = 4;
    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [3:0]  an_out;
    logic        frame_tick;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       ft;
    } exp_t;

    exp_t expQ[$];
    int   checks   = 0;
    int   failures = 0;
    int   cycleNum = 0;

    int          mCnt;
    logic [15:0] mShadow;
    logic [3:0]  mDp;
    bit          mPending;

    bcd_display_scanner #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (DIV),
        .ACTIVE_LOW  (1'b0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .seg_out    (seg_out),
        .dp_out     (dp_out),
        .an_out     (an_out),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input int v);
        case (v)
            0:       return 7'b0111111;
            1:       return 7'b0000110;
            2:       return 7'b1011011;
            3:       return 7'b1001111;
            4:       return 7'b1100110;
            5:       return 7'b1101101;
            6:       return 7'b1111101;
            7:       return 7'b0000111;
            8:       return 7'b1111111;
            9:       return 7'b1101111;
            default: return 7'b1000000;
        endcase
    endfunction

    // Reference: the lit digit and frame boundary follow from the number of enabled cycles.
    always @(posedge clk) begin
        exp_t e;
        int   d;
        int   v;
        e = '0;
        if (reset) begin
            mCnt     = 0;
            mShadow  = '0;
            mDp      = '0;
            mPending = 1'b0;
        end else if (enable) begin
            d      = (mCnt / DIV) % N;
            v      = int'((mShadow >> (4 * d)) & 16'hF);
            e.an   = 4'(1 << d);
            e.seg  = (blank_lz && d > 0 && (mShadow >> (4 * d)) == 16'h0) ? 7'b0 : glyph(v);
            e.dp   = mDp[d];
            e.ft   = mPending;
            mPending = 1'b0;
            mCnt++;
            if (mCnt % (DIV * N) == 0) begin
                mShadow  = digits_in;
                mDp      = dp_in;
                mPending = 1'b1;
            end
        end
        expQ.push_back(e);
    end

    task automatic checkOutput(input exp_t e);
        checks++;
        if ({an_out, seg_out, dp_out, frame_tick} !== e) begin
            failures++;
            $display("[TB] FAIL pins cycle %0d: got an=%b seg=%b dp=%b tick=%b, want an=%b seg=%b dp=%b tick=%b",
                     cycleNum, an_out, seg_out, dp_out, frame_tick, e.an, e.seg, e.dp, e.ft);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        cycleNum++;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e);
        end
    end

    task automatic applyStimulus(input logic rst, input logic en, input logic [15:0] dig,
                                 input logic [3:0] dp, input logic blz, input int cycles);
        reset     = rst;
        enable    = en;
        digits_in = dig;
        dp_in     = dp;
        blank_lz  = blz;
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        logic [15:0] rdig;
        $display("[TB] start");
        applyStimulus(1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0, 2);
        applyStimulus(1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0, 10);
        applyStimulus(1'b0, 1'b1, 16'h1234, 4'b0000, 1'b0, 32);
        applyStimulus(1'b0, 1'b1, 16'h0050, 4'b0000, 1'b1, 40);
        applyStimulus(1'b0, 1'b1, 16'h0000, 4'b0000, 1'b1, 40);
        applyStimulus(1'b0, 1'b1, 16'h00A9, 4'b0100, 1'b0, 40);
        // Source changes while digit 2 is lit in the frame showing 1234.
        applyStimulus(1'b1, 1'b0, 16'h1234, 4'b0000, 1'b0, 1);
        applyStimulus(1'b0, 1'b1, 16'h1234, 4'b0000, 1'b0, 24);
        applyStimulus(1'b0, 1'b1, 16'h5678, 4'b0000, 1'b0, 24);
        // Reset mid-scan, then an 8-cycle enable drop in the middle of a digit.
        applyStimulus(1'b0, 1'b1, 16'h4321, 4'b1010, 1'b0, 14);
        applyStimulus(1'b1, 1'b1, 16'h4321, 4'b1010, 1'b0, 1);
        applyStimulus(1'b0, 1'b1, 16'h4321, 4'b1010, 1'b0, 6);
        applyStimulus(1'b0, 1'b0, 16'h4321, 4'b1010, 1'b0, 8);
        applyStimulus(1'b0, 1'b1, 16'h4321, 4'b1010, 1'b0, 40);
        for (int i = 0; i < 80; i++) begin
            rdig = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 3)));
            applyStimulus(($urandom % 40) == 0, ($urandom % 8) != 0, rdig,
                          4'($urandom), 1'($urandom), $urandom_range(1, 12));
        end
        applyStimulus(1'b0, 1'b1, 16'h9087, 4'b0001, 1'b1, 40);
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
